// File: rtl/pe_ws_mac.sv
// pe_ws_mac: weight-stationary systolic PE with double-buffered weight and saturating MAC
module pe_ws_mac #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int SIGNED = 1,
  parameter int SAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a_in,
  input  logic              a_vld_in,
  output logic [DATA_W-1:0] a_out,
  output logic              a_vld_out,
  input  logic [DATA_W-1:0] w_in,
  input  logic              w_load_in,
  output logic [DATA_W-1:0] w_out,
  output logic              w_load_out,
  input  logic              w_swap_in,
  output logic              w_swap_out,
  input  logic [ACC_W-1:0]  psum_in,
  output logic [ACC_W-1:0]  psum_out,
  output logic              psum_vld_out,
  output logic              sat_out
);
  localparam int EW = ACC_W + 1 - 2 * DATA_W;
  localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};
  if (ACC_W < 2 * DATA_W) begin : g_chk
    $error("pe_ws_mac: ACC_W must be at least 2*DATA_W");
  end
  logic [DATA_W-1:0] active;
  logic signed [2*DATA_W-1:0] prod_s;
  logic [2*DATA_W-1:0] prod_u;
  logic [ACC_W:0] sum;
  logic [ACC_W-1:0] res;
  logic ovf;
  assign prod_s = $signed(a_in) * $signed(active);
  assign prod_u = a_in * active;
  // Extend product and psum one bit past ACC_W so the add never loses a carry, then clamp or wrap
  always_comb begin
    sum = ((SIGNED != 0) ? {{EW{prod_s[2*DATA_W-1]}}, prod_s} : {{EW{1'b0}}, prod_u})
        + {(SIGNED != 0) ? psum_in[ACC_W-1] : 1'b0, psum_in};
    ovf = (SAT == 0) ? 1'b0 : (SIGNED != 0) ? sum[ACC_W] ^ sum[ACC_W-1] : sum[ACC_W];
    res = !ovf ? sum[ACC_W-1:0] : (SIGNED != 0) ? (sum[ACC_W] ? SMIN : SMAX) : {ACC_W{1'b1}};
  end
  // Activation, weight chain and psum pipelines all advance in parallel; active only changes on swap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_out        <= '0;
      a_vld_out    <= 1'b0;
      w_out        <= '0;
      active       <= '0;
      w_load_out   <= 1'b0;
      w_swap_out   <= 1'b0;
      psum_out     <= '0;
      psum_vld_out <= 1'b0;
      sat_out      <= 1'b0;
    end else begin
      a_vld_out    <= a_vld_in;
      w_load_out   <= w_load_in;
      w_swap_out   <= w_swap_in;
      psum_vld_out <= a_vld_in;
      if (a_vld_in) begin
        a_out    <= a_in;
        psum_out <= res;
        sat_out  <= ovf;
      end
      if (w_load_in) w_out <= w_in;
      if (w_swap_in) active <= w_out;
    end
  end
endmodule

// File: doc/pe_ws_mac.md
PE_WS_MAC -- requirements
Module: pe_ws_mac

Interface
REQ-001 Parameter DATA_W, default 8: width of activation and weight operands.
REQ-002 Parameter ACC_W, default 20: width of partial sum in and out; ACC_W >= 2*DATA_W SHALL hold, else elaboration fails.
REQ-003 Parameter SIGNED, default 1: 1 = two's-complement operands and psum, 0 = unsigned.
REQ-004 Parameter SAT, default 1: 1 = saturate psum_out, 0 = wrap modulo 2^ACC_W.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  reset; asynchronous, active-high.
REQ-007 a_in  in  DATA_W  activation from left neighbour.
REQ-008 a_vld_in  in  1  activation valid.
REQ-009 a_out  out  DATA_W  registered activation to right neighbour.
REQ-010 a_vld_out  out  1  registered a_vld_in.
REQ-011 w_in  in  DATA_W  weight shift-chain input from upper neighbour.
REQ-012 w_load_in  in  1  weight-shift enable.
REQ-013 w_out  out  DATA_W  shadow weight register, shift-chain output.
REQ-014 w_load_out  out  1  registered w_load_in.
REQ-015 w_swap_in  in  1  promote shadow weight to active weight.
REQ-016 w_swap_out  out  1  registered w_swap_in.
REQ-017 psum_in  in  ACC_W  partial sum from upper neighbour.
REQ-018 psum_out  out  ACC_W  registered partial sum.
REQ-019 psum_vld_out  out  1  psum_out valid.
REQ-020 sat_out  out  1  saturation occurred on the current psum_out.

Function
REQ-021 All outputs and the shadow/active weight registers SHALL be registered; every pipeline latency is exactly 1 cycle.
REQ-022 a_vld_in=1: a_out <= a_in; a_vld_in=0: a_out holds; a_vld_out <= a_vld_in every cycle.
REQ-023 w_load_in=1: shadow <= w_in; else shadow holds; w_out is the shadow register; w_load_out <= w_load_in every cycle.
REQ-024 w_swap_in=1: active <= shadow (value before this edge); w_swap_out <= w_swap_in every cycle.
REQ-025 w_load_in and w_swap_in in same cycle: active gets old shadow, shadow gets w_in.
REQ-026 a_vld_in=1: psum_out <= fmt(a_in * active + psum_in), psum_vld_out <= 1, using active value before this edge (swap in same cycle takes effect next cycle).
REQ-027 a_vld_in=0: psum_out and sat_out hold, psum_vld_out <= 0.
REQ-028 Product 2*DATA_W bits, sign-extended (SIGNED=1) or zero-extended (SIGNED=0) to ACC_W+1 bits; psum_in extended likewise; sum computed at ACC_W+1 bits, no intermediate loss.
REQ-029 SAT=1, SIGNED=1: clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; SIGNED=0: clamp to [0, 2^ACC_W-1]; sat_out <= 1 when a clamp occurred, else 0.
REQ-030 SAT=0: psum_out <= low ACC_W bits of sum; sat_out <= 0 always.
REQ-031 Weight chain, activation path and psum path SHALL operate independently and concurrently; loading shadow while computing SHALL NOT disturb active.

Reset
REQ-032 rst=1 SHALL immediately clear a_out, a_vld_out, w_out/shadow, active, w_load_out, w_swap_out, psum_out, psum_vld_out, sat_out to 0, regardless of clk.
REQ-033 Reset mid-operation SHALL discard in-flight data; first valid after release multiplies by active=0 until a swap occurs.

Verification
REQ-034 Defaults; w_in=5,w_load_in=1 one cycle, then w_swap_in=1 one cycle, then a_in=8'hFD(-3),a_vld_in=1,psum_in=100 -> next cycle psum_out=85, psum_vld_out=1, sat_out=0, a_out=8'hFD.
REQ-035 Defaults, active=1; a_in=1, psum_in=524287 -> psum_out=524287, sat_out=1; a_in=8'h80,active=127,psum_in=-524288 -> psum_out=-524288, sat_out=1.
REQ-036 SIGNED=0,SAT=0,ACC_W=16, active=255; a_in=255, psum_in=16'hFFFF -> psum_out=16'hFE00, sat_out=0.
REQ-037 Chain: w_in=3 then 7 on consecutive cycles with w_load_in=1 -> w_out=3 after first edge, 7 after second; w_load_out trails by one cycle; active unchanged without swap.
REQ-038 Same-cycle w_swap_in=1 and a_vld_in=1 with active=2, shadow=9, a_in=1, psum_in=0 -> psum_out=2; next valid with a_in=1 -> psum_out=9.
REQ-039 rst pulsed between clock edges mid-stream -> all outputs 0 before next edge; a_vld_in=1,a_in=4,psum_in=6 after release -> psum_out=6.
